// File: rtl/decoder_scan.sv
// Registered one-hot select generator with direct-decode and auto-stepping scan modes.
// Every output is registered; out-of-range loads pulse err, and scan wrap-around pulses wrap.
module decoder_scan #(
    parameter int unsigned OUTPUTS = 32,
    parameter int unsigned PULSE   = 0,
    localparam int unsigned W      = $clog2(OUTPUTS)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               mode_i,
    input  logic               ena_i,
    input  logic               load_i,
    input  logic [W-1:0]       in_i,
    input  logic               step_i,
    output logic [OUTPUTS-1:0] out_o,
    output logic [W-1:0]       index_o,
    output logic               wrap_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        StIdle,
        StDirect,
        StScan
    } state_e;

    localparam logic [W-1:0] LastIdx = W'(OUTPUTS - 1);

    state_e             state_q, state_d;
    logic [W-1:0]       index_q, index_d;
    logic [OUTPUTS-1:0] out_q, out_d;
    logic               wrap_q, wrap_d;
    logic               err_q, err_d;
    logic               in_range;

    function automatic logic [OUTPUTS-1:0] onehot(input logic [W-1:0] idx);
        logic [OUTPUTS-1:0] v;
        v = '0;
        for (int unsigned i = 0; i < OUTPUTS; i++) begin
            if (idx == W'(i)) begin
                v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    // A power-of-two output count covers every encodable index, so no check is needed.
    if (OUTPUTS == (1 << W)) begin : gen_full_range
        assign in_range = 1'b1;
    end else begin : gen_range_check
        localparam logic [W-1:0] OutLimit = W'(OUTPUTS);
        assign in_range = (in_i < OutLimit);
    end

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        out_d   = '0;
        wrap_d  = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            StIdle: begin
                if (mode_i) begin
                    state_d = StScan;
                    out_d   = ena_i ? onehot(index_q) : '0;
                end else if (load_i) begin
                    state_d = StDirect;
                    if (in_range) begin
                        index_d = in_i;
                        out_d   = ena_i ? onehot(in_i) : '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StDirect: begin
                if (mode_i) begin
                    // Mode change wins over any load issued in the same cycle.
                    state_d = StIdle;
                    index_d = '0;
                end else if (load_i) begin
                    if (in_range) begin
                        index_d = in_i;
                        out_d   = ena_i ? onehot(in_i) : '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (PULSE != 0) begin
                    state_d = StIdle;
                end else begin
                    out_d = ena_i ? out_q : '0;
                end
            end

            StScan: begin
                if (!mode_i) begin
                    state_d = StIdle;
                    index_d = '0;
                end else begin
                    // Load has priority over step; a suppressed step never wraps.
                    if (load_i) begin
                        if (in_range) begin
                            index_d = in_i;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else if (step_i && ena_i) begin
                        if (index_q == LastIdx) begin
                            index_d = '0;
                            wrap_d  = 1'b1;
                        end else begin
                            index_d = index_q + W'(1);
                        end
                    end
                    out_d = ena_i ? onehot(index_d) : '0;
                end
            end

            default: begin
                state_d = StIdle;
                index_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            index_q <= '0;
            out_q   <= '0;
            wrap_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            out_q   <= out_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
        end
    end

    assign out_o   = out_q;
    assign index_o = index_q;
    assign wrap_o  = wrap_q;
    assign err_o   = err_q;

    a_out_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(out_q));

endmodule

// File: tb/tb_decoder_scan.sv
// Bench for decoder_scan: four instances (32/20 outputs, level/pulse) share one stimulus
// stream; directed scenarios use hand-derived constants, random traffic uses an int-level model.
module tb_decoder_scan;

    localparam int S_IDLE   = 0;
    localparam int S_DIRECT = 1;
    localparam int S_SCAN   = 2;

    logic        clk;
    logic        rst_n;
    logic        mode, ena, load, step;
    logic [4:0]  in_v;
    logic [31:0] out0, out1;
    logic [19:0] out2, out3;
    logic [4:0]  idx0, idx1, idx2, idx3;
    logic [3:0]  wrap_v, err_v;

    int asserts = 0;
    int fails   = 0;

    int m_n[4]     = '{32, 32, 20, 20};
    int m_p[4]     = '{0, 1, 0, 1};
    int m_state[4];
    int m_idx[4];
    int m_shown[4];
    bit m_wrap[4];
    bit m_err[4];

    decoder_scan #(.OUTPUTS(32), .PULSE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .ena_i(ena), .load_i(load),
        .in_i(in_v), .step_i(step), .out_o(out0), .index_o(idx0), .wrap_o(wrap_v[0]),
        .err_o(err_v[0])
    );
    decoder_scan #(.OUTPUTS(32), .PULSE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .ena_i(ena), .load_i(load),
        .in_i(in_v), .step_i(step), .out_o(out1), .index_o(idx1), .wrap_o(wrap_v[1]),
        .err_o(err_v[1])
    );
    decoder_scan #(.OUTPUTS(20), .PULSE(0)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .ena_i(ena), .load_i(load),
        .in_i(in_v), .step_i(step), .out_o(out2), .index_o(idx2), .wrap_o(wrap_v[2]),
        .err_o(err_v[2])
    );
    decoder_scan #(.OUTPUTS(20), .PULSE(1)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .mode_i(mode), .ena_i(ena), .load_i(load),
        .in_i(in_v), .step_i(step), .out_o(out3), .index_o(idx3), .wrap_o(wrap_v[3]),
        .err_o(err_v[3])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    function automatic logic [31:0] dut_out(int k);
        case (k)
            0:       return out0;
            1:       return out1;
            2:       return {12'b0, out2};
            default: return {12'b0, out3};
        endcase
    endfunction

    function automatic logic [31:0] dut_idx(int k);
        case (k)
            0:       return {27'b0, idx0};
            1:       return {27'b0, idx1};
            2:       return {27'b0, idx2};
            default: return {27'b0, idx3};
        endcase
    endfunction

    function automatic logic [31:0] exp_out(int k);
        logic [31:0] v;
        v = '0;
        if (m_shown[k] >= 0) v[m_shown[k]] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_state[k] = S_IDLE;
            m_idx[k]   = 0;
            m_shown[k] = -1;
            m_wrap[k]  = 1'b0;
            m_err[k]   = 1'b0;
        end
    endtask

    // Next-cycle behaviour for every instance, taken from the current input values.
    task automatic model_clock();
        for (int k = 0; k < 4; k++) begin
            int  n;
            int  iv;
            bit  inr;
            n   = m_n[k];
            iv  = int'(in_v);
            inr = (iv < n);
            m_wrap[k] = 1'b0;
            m_err[k]  = 1'b0;
            if (m_state[k] == S_IDLE) begin
                m_shown[k] = -1;
                if (mode) begin
                    m_state[k] = S_SCAN;
                    m_shown[k] = ena ? m_idx[k] : -1;
                end else if (load) begin
                    m_state[k] = S_DIRECT;
                    if (inr) begin
                        m_idx[k]   = iv;
                        m_shown[k] = ena ? iv : -1;
                    end else m_err[k] = 1'b1;
                end
            end else if (m_state[k] == S_DIRECT) begin
                if (mode) begin
                    m_state[k] = S_IDLE;
                    m_idx[k]   = 0;
                    m_shown[k] = -1;
                end else if (load) begin
                    if (inr) begin
                        m_idx[k]   = iv;
                        m_shown[k] = ena ? iv : -1;
                    end else begin
                        m_err[k]   = 1'b1;
                        m_shown[k] = -1;
                    end
                end else if (m_p[k] != 0) begin
                    m_state[k] = S_IDLE;
                    m_shown[k] = -1;
                end else if (!ena) m_shown[k] = -1;
            end else begin
                if (!mode) begin
                    m_state[k] = S_IDLE;
                    m_idx[k]   = 0;
                    m_shown[k] = -1;
                end else begin
                    if (load) begin
                        if (inr) m_idx[k] = iv;
                        else m_err[k] = 1'b1;
                    end else if (step && ena) begin
                        if (m_idx[k] == n - 1) begin
                            m_idx[k]  = 0;
                            m_wrap[k] = 1'b1;
                        end else m_idx[k] = m_idx[k] + 1;
                    end
                    m_shown[k] = ena ? m_idx[k] : -1;
                end
            end
        end
    endtask

    task automatic tick();
        if (rst_n) model_clock();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        mode = 1'b0; ena = 1'b0; load = 1'b0; step = 1'b0; in_v = '0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            asserts++;
            if (dut_out(k) !== 32'h0) begin
                fails++; $display("FAIL reset_out[%0d]: got %h want 0", k, dut_out(k));
            end
            asserts++;
            if (dut_idx(k) !== 32'h0) begin
                fails++; $display("FAIL reset_idx[%0d]: got %0d want 0", k, dut_idx(k));
            end
            asserts++;
            if (wrap_v[k] !== 1'b0 || err_v[k] !== 1'b0) begin
                fails++;
                $display("FAIL reset_flags[%0d]: got wrap=%b err=%b want 0 0", k, wrap_v[k], err_v[k]);
            end
        end
    endtask

    task automatic test_direct_hold();
        do_reset();
        mode = 1'b0; ena = 1'b1; load = 1'b1; in_v = 5'd5;
        tick();
        load = 1'b0;
        asserts++;
        if (out0 !== 32'h0000_0020 || idx0 !== 5'd5) begin
            fails++; $display("FAIL hold_first: got out=%h idx=%0d want 00000020 5", out0, idx0);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            asserts++;
            if (out0 !== 32'h0000_0020) begin
                fails++; $display("FAIL hold_cycle%0d: got %h want 00000020", i, out0);
            end
        end
        #3;
        rst_n = 1'b0;
        #1;
        asserts++;
        if (out0 !== 32'h0 || idx0 !== 5'd0) begin
            fails++; $display("FAIL async_reset: got out=%h idx=%0d want 0 0", out0, idx0);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_pulse();
        do_reset();
        mode = 1'b0; ena = 1'b1; load = 1'b1; in_v = 5'd31;
        tick();
        load = 1'b0;
        asserts++;
        if (out1 !== 32'h8000_0000) begin
            fails++; $display("FAIL pulse_on: got %h want 80000000", out1);
        end
        tick();
        asserts++;
        if (out1 !== 32'h0) begin
            fails++; $display("FAIL pulse_off: got %h want 0", out1);
        end
        ena = 1'b0; load = 1'b1; in_v = 5'd31;
        tick();
        load = 1'b0;
        asserts++;
        if (out1 !== 32'h0 || idx1 !== 5'd31) begin
            fails++; $display("FAIL pulse_ena_low: got out=%h idx=%0d want 0 31", out1, idx1);
        end
        ena = 1'b1;
        tick();
        asserts++;
        if (out1 !== 32'h0 || err_v[1] !== 1'b0) begin
            fails++; $display("FAIL pulse_after: got out=%h err=%b want 0 0", out1, err_v[1]);
        end
    endtask

    task automatic test_range();
        do_reset();
        mode = 1'b0; ena = 1'b1; load = 1'b1; in_v = 5'd19;
        tick();
        load = 1'b0;
        asserts++;
        if (out2 !== 20'h8_0000 || err_v[2] !== 1'b0) begin
            fails++; $display("FAIL range_19: got out=%h err=%b want 80000 0", out2, err_v[2]);
        end
        load = 1'b1; in_v = 5'd20;
        tick();
        load = 1'b0;
        asserts++;
        if (err_v[2] !== 1'b1 || out2 !== 20'h0 || idx2 !== 5'd19) begin
            fails++;
            $display("FAIL range_20: got err=%b out=%h idx=%0d want 1 0 19", err_v[2], out2, idx2);
        end
        asserts++;
        if (err_v[0] !== 1'b0 || out0 !== 32'h0010_0000 || idx0 !== 5'd20) begin
            fails++;
            $display("FAIL range_pow2: got err=%b out=%h idx=%0d want 0 00100000 20",
                     err_v[0], out0, idx0);
        end
        tick();
        asserts++;
        if (err_v[2] !== 1'b0) begin
            fails++; $display("FAIL range_err_width: got %b want 0", err_v[2]);
        end
    endtask

    task automatic test_scan_walk();
        logic [19:0] ev;
        do_reset();
        mode = 1'b1; ena = 1'b1; step = 1'b0;
        tick();
        asserts++;
        if (out2 !== 20'h1 || wrap_v[2] !== 1'b0) begin
            fails++; $display("FAIL walk_entry: got out=%h wrap=%b want 00001 0", out2, wrap_v[2]);
        end
        step = 1'b1;
        for (int i = 1; i < 25; i++) begin
            int e;
            e = i % 20;
            tick();
            ev = '0;
            ev[e] = 1'b1;
            asserts++;
            if (out2 !== ev || idx2 !== 5'(e) || wrap_v[2] !== (e == 0)) begin
                fails++;
                $display("FAIL walk_%0d: got out=%h idx=%0d wrap=%b want %h %0d %b",
                         i, out2, idx2, wrap_v[2], ev, e, (e == 0));
            end
        end
        ena = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if (out2 !== 20'h0 || idx2 !== 5'd4) begin
                fails++; $display("FAIL walk_freeze%0d: got out=%h idx=%0d want 0 4", i, out2, idx2);
            end
        end
        ena = 1'b1; step = 1'b0;
        tick();
        asserts++;
        if (out2 !== 20'h10 || idx2 !== 5'd4) begin
            fails++; $display("FAIL walk_resume: got out=%h idx=%0d want 00010 4", out2, idx2);
        end
    endtask

    task automatic test_load_step_priority();
        do_reset();
        mode = 1'b1; ena = 1'b1; step = 1'b0;
        tick();
        load = 1'b1; in_v = 5'd31;
        tick();
        asserts++;
        if (idx0 !== 5'd31 || err_v[2] !== 1'b1 || idx2 !== 5'd0 || out2 !== 20'h1) begin
            fails++;
            $display("FAIL prio_load31: got idx0=%0d err2=%b idx2=%0d out2=%h want 31 1 0 00001",
                     idx0, err_v[2], idx2, out2);
        end
        in_v = 5'd7; step = 1'b1;
        tick();
        asserts++;
        if (idx0 !== 5'd7 || wrap_v[0] !== 1'b0 || out0 !== 32'h80 || idx2 !== 5'd7) begin
            fails++;
            $display("FAIL prio_load_step: got idx0=%0d wrap=%b out0=%h idx2=%0d want 7 0 80 7",
                     idx0, wrap_v[0], out0, idx2);
        end
        in_v = 5'd22;
        tick();
        asserts++;
        if (err_v[2] !== 1'b1 || idx2 !== 5'd7 || out2 !== 20'h80 || idx0 !== 5'd22) begin
            fails++;
            $display("FAIL prio_oor_step: got err2=%b idx2=%0d out2=%h idx0=%0d want 1 7 00080 22",
                     err_v[2], idx2, out2, idx0);
        end
        mode = 1'b0; in_v = 5'd3; step = 1'b0;
        tick();
        load = 1'b0;
        asserts++;
        if (out0 !== 32'h0 || idx0 !== 5'd0 || idx2 !== 5'd0) begin
            fails++;
            $display("FAIL mode_switch: got out0=%h idx0=%0d idx2=%0d want 0 0 0", out0, idx0, idx2);
        end
        tick();
        asserts++;
        if (out0 !== 32'h0 || idx0 !== 5'd0) begin
            fails++; $display("FAIL mode_idle: got out0=%h idx0=%0d want 0 0", out0, idx0);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 10000; c++) begin
            if ($urandom_range(0, 63) == 0) mode = ~mode;
            ena  = ($urandom_range(0, 4) != 0);
            load = ($urandom_range(0, 7) == 0);
            step = $urandom_range(0, 1) == 1;
            in_v = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 999) == 0) begin
                rst_n = 1'b0;
                model_reset();
            end
            tick();
            rst_n = 1'b1;
            for (int k = 0; k < 4; k++) begin
                asserts++;
                if (dut_out(k) !== exp_out(k)) begin
                    fails++;
                    $display("FAIL rand_out[%0d] cyc %0d: got %h want %h", k, c, dut_out(k), exp_out(k));
                end
                asserts++;
                if (dut_idx(k) !== 32'(m_idx[k])) begin
                    fails++;
                    $display("FAIL rand_idx[%0d] cyc %0d: got %0d want %0d", k, c, dut_idx(k), m_idx[k]);
                end
                asserts++;
                if (wrap_v[k] !== m_wrap[k] || err_v[k] !== m_err[k]) begin
                    fails++;
                    $display("FAIL rand_flags[%0d] cyc %0d: got wrap=%b err=%b want %b %b",
                             k, c, wrap_v[k], err_v[k], m_wrap[k], m_err[k]);
                end
                asserts++;
                if ($countones(dut_out(k)) > 1) begin
                    fails++;
                    $display("FAIL rand_onehot[%0d] cyc %0d: got %h want at most one bit", k, c,
                             dut_out(k));
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mode = 1'b0; ena = 1'b0; load = 1'b0; step = 1'b0; in_v = '0;
        model_reset();
        test_reset();
        test_direct_hold();
        test_pulse();
        test_range();
        test_scan_walk();
        test_load_step_priority();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule

// File: doc/decoder_scan.md
# decoder_scan

Registered, parametrised one-hot select generator; the sequential successor to the 5-to-32 combinational decoder. It drives register-file write enables, mux selects and peripheral chip-selects. Two modes are supported: direct decode of a loaded index, and an auto-stepping scan with wrap indication. Output count need not be a power of two, and out-of-range indices are flagged.

## Interface
- `OUTPUTS`, default 32: number of one-hot output lines; legal range 2..256.
- `PULSE`, default 0: 1 means a direct-mode decode asserts for exactly one cycle; 0 means it holds until changed.
- `W` (localparam) = `$clog2(OUTPUTS)`: index width.
- `clk`  in  1: rising-edge clock, the only clock.
- `rst_n`  in  1: asynchronous, active-low reset.
- `mode`  in  1: 0 selects direct, 1 selects scan.
- `ena`  in  1: output enable. When low, `out` goes to 0 on the next edge and the state/index are preserved.
- `load`  in  1: load request; captures `in`.
- `in`  in  W: index to decode or load.
- `step`  in  1: scan-mode advance request.
- `out`  out  OUTPUTS: registered one-hot select, all-zero when idle.
- `index`  out  W: currently held index.
- `wrap`  out  1: one-cycle pulse when the scan wraps from `OUTPUTS-1` to 0.
- `err`  out  1: one-cycle pulse when `load` is issued with `in >= OUTPUTS`.

## Operation
- States are IDLE, DIRECT and SCAN. Reset enters IDLE.
- IDLE: `out`=0. Next state is DIRECT when `mode`=0 and `load`=1, and SCAN when `mode`=1.
- DIRECT:
  - `load`=1 with `in` in range: `index`<=`in`. `out`<=one-hot(`in`) if `ena`=1, else 0.
  - `load`=1 with `in` out of range: `err`=1, `out`<=0, `index` unchanged.
  - `PULSE`=1: `out` returns to 0 on the cycle after assertion and the state returns to IDLE.
  - `PULSE`=0: `out` holds.
  - `step` is ignored in DIRECT.
- SCAN:
  - `out` = one-hot(`index`) whenever `ena`=1, else 0.
  - `step`=1 and `ena`=1: `index`<=`index`+1. At `index`==`OUTPUTS-1` it instead becomes 0 and `wrap` pulses.
  - `step` while `ena`=0 is ignored, so the index does not advance.
  - `load` has priority over `step`. An in-range load sets `index`<=`in`; an out-of-range load pulses `err` and keeps `index`.
- Mode change: if `mode` differs from the current state's mode, the block goes to IDLE on the next edge with `out`<=0 and `index`<=0. A load in that same cycle is discarded.
- Invariant: `popcount(out)` <= 1 in every cycle, including reset and mode switches.
- Range check: `in` is compared against `OUTPUTS` at full width W. For a power-of-two `OUTPUTS`, `err` can never fire.

## Timing
- Reset values: `out`=0, `index`=0, `wrap`=0, `err`=0, state IDLE. Reset takes effect immediately on `rst_n` falling, whatever the cycle phase or operation in progress.
- Leaving reset: the first edge with `rst_n`=1 evaluates inputs normally.
- Latency: `load`/`step`/`ena` to `out`/`index`/`wrap`/`err` is exactly 1 clock. All outputs are registered, with no combinational path from input to output.
- `wrap` and `err` are high for exactly one cycle per event.
- Back-to-back `step` every cycle advances `index` every cycle, with no bubbles.
- Simultaneous `load` and `step`: only the load applies. No `wrap` pulses, even if `index` was `OUTPUTS-1`.
- Simultaneous out-of-range `load` and `step` in SCAN: `err` pulses and `index` is unchanged; the step is not applied.

## Test plan
- Reset, then `mode`=0, `ena`=1, `load`=1, `in`=5 (OUTPUTS=32, PULSE=0) -> next cycle `out`=32'h0000_0020, `index`=5, holding for 10 idle cycles. Assert `rst_n`=0 mid-hold -> `out`=0 immediately.
- `PULSE`=1, load `in`=31 -> `out`=32'h8000_0000 for exactly one cycle, then 0 and state IDLE. Load with `ena`=0 -> `out` stays 0 and `index`=31.
- `OUTPUTS`=20, direct load `in`=19 -> `out` bit 19 set. Load `in`=20 -> `err` pulses one cycle, `out`=0, `index` stays 19.
- Scan, `OUTPUTS`=20, `ena`=1, `step` held high 25 cycles from index 0 -> `out` walks bits 0..19,0..4. `wrap` is high only in the cycle `index` returns to 0. `ena` dropped for 3 cycles mid-walk -> `out`=0 and `index` frozen.
- Scan at `index`=31, same-cycle `load`=1, `in`=7, `step`=1 -> `index`=7, `wrap`=0. Then toggle `mode` to 0 -> next cycle `out`=0, `index`=0, state IDLE.
- Random 10k-cycle stimulus across both modes and both `PULSE` settings -> `popcount(out)` <= 1 in every cycle, and `out` matches a cycle-accurate reference model.
